// File: rtl/wb_ctrl_if.sv
// Control link between the sequencer (master) and the white balance corrector (slave).
interface wb_ctrl_if;
    logic [1:0]  mode;
    logic [1:0]  man_sel;
    logic [31:0] man_coef;
    logic        man_lock;
    logic        cal_stb;
    logic [31:0] cur_coef;

    modport master (
        output mode, man_sel, man_coef, man_lock, cal_stb,
        input  cur_coef
    );

    modport slave (
        input  mode, man_sel, man_coef, man_lock, cal_stb,
        output cur_coef
    );
endinterface

// File: rtl/wb_ctrl_sequencer.sv
// CSR-to-corrector sequencer: turns single CSR accesses into man_sel/man_coef/man_lock
// sequences, reads back the live coefficient, and runs frame-counted calibration.
module wb_ctrl_sequencer #(
    parameter int PX_WIDTH    = 10,
    parameter int FRACT_WIDTH = 10,
    parameter int CAL_FRAMES  = 2,
    parameter int RD_WAIT     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  csr_addr_i,
    input  logic        csr_wr_i,
    input  logic        csr_rd_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        csr_ready_o,
    input  logic        sof_i,
    wb_ctrl_if.master   wb_ctrl_o
);
    localparam int COEF_WIDTH = PX_WIDTH + FRACT_WIDTH;
    localparam int RC_W       = $clog2(RD_WAIT + 1);

    // Command FSM
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WR_LOCK = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_CAP  = 2'd3;

    // Calibration FSM
    localparam logic [1:0] CAL_IDLE  = 2'd0;
    localparam logic [1:0] CAL_COUNT = 2'd1;
    localparam logic [1:0] CAL_FIRE  = 2'd2;

    localparam logic [2:0] A_MODE = 3'd0;
    localparam logic [2:0] A_CAL  = 3'd4;

    logic [1:0]      st_q, st_d;
    logic [RC_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]      cal_st_q, cal_st_d;
    logic [7:0]      cal_cnt_q, cal_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      man_sel_q, man_sel_d;
    logic [31:0]     man_coef_q, man_coef_d;
    logic            man_lock_q, man_lock_d;
    logic            cal_stb_q, cal_stb_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;

    logic            arm, cancel, done_clr;
    logic            is_coef;
    logic [31:0]     rd_coef;

    assign is_coef = (csr_addr_i >= 3'd1) && (csr_addr_i <= 3'd3);

    // Only the coefficient field of cur_coef is returned; upper bits read as zero
    always_comb begin
        rd_coef = '0;
        rd_coef[COEF_WIDTH-1:0] = wb_ctrl_o.cur_coef[COEF_WIDTH-1:0];
    end

    generate
        if (COEF_WIDTH < 32) begin : g_unused
            logic unused_cur_coef;
            assign unused_cur_coef = &{1'b0, wb_ctrl_o.cur_coef[31:COEF_WIDTH]};
        end
    endgenerate

    // Next-state logic for the command and calibration FSMs
    always_comb begin
        st_d       = st_q;
        rd_cnt_d   = rd_cnt_q;
        cal_st_d   = cal_st_q;
        cal_cnt_d  = cal_cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mode_d     = mode_q;
        man_sel_d  = man_sel_q;
        man_coef_d = man_coef_q;
        man_lock_d = 1'b0;
        cal_stb_d  = 1'b0;
        rdata_d    = '0;
        ready_d    = 1'b0;
        arm        = 1'b0;
        cancel     = 1'b0;
        done_clr   = 1'b0;

        case (st_q)
            ST_IDLE: begin
                if (csr_wr_i) begin
                    // Write wins over a simultaneous read
                    if (is_coef) begin
                        man_sel_d  = csr_addr_i[1:0] - 2'd1;
                        man_coef_d = csr_wdata_i;
                        man_lock_d = 1'b1;
                        st_d       = ST_WR_LOCK;
                    end else begin
                        ready_d = 1'b1;
                        if (csr_addr_i == A_MODE) begin
                            mode_d = csr_wdata_i[1:0];
                            cancel = busy_q;
                        end else if (csr_addr_i == A_CAL) begin
                            arm = csr_wdata_i[0];
                        end
                    end
                end else if (csr_rd_i) begin
                    if (is_coef) begin
                        man_sel_d = csr_addr_i[1:0] - 2'd1;
                        rd_cnt_d  = RC_W'(RD_WAIT);
                        st_d      = ST_RD_WAIT;
                    end else begin
                        ready_d = 1'b1;
                        if (csr_addr_i == A_MODE) begin
                            rdata_d = {30'd0, mode_q};
                        end else if (csr_addr_i == A_CAL) begin
                            rdata_d  = {30'd0, done_q, busy_q};
                            done_clr = 1'b1;
                        end
                    end
                end
            end
            ST_WR_LOCK: begin
                ready_d = 1'b1;
                st_d    = ST_IDLE;
            end
            ST_RD_WAIT: begin
                rd_cnt_d = rd_cnt_q - RC_W'(1);
                if (rd_cnt_q == RC_W'(1)) st_d = ST_RD_CAP;
            end
            default: begin
                rdata_d = rd_coef;
                ready_d = 1'b1;
                st_d    = ST_IDLE;
            end
        endcase

        // Read-clear happens first so a same-cycle completion still leaves done set
        if (done_clr) done_d = 1'b0;

        if (arm) begin
            // Arming freezes the corrector and restarts the frame count; the
            // coincident sof is deliberately not counted
            mode_d    = 2'd3;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            cal_cnt_d = '0;
            cal_st_d  = CAL_COUNT;
        end else if (cancel) begin
            busy_d   = 1'b0;
            cal_st_d = CAL_IDLE;
        end else begin
            case (cal_st_q)
                CAL_COUNT: begin
                    if (sof_i) begin
                        cal_cnt_d = cal_cnt_q + 8'd1;
                        if (cal_cnt_q + 8'd1 == 8'(CAL_FRAMES)) begin
                            cal_stb_d = 1'b1;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            cal_st_d  = CAL_FIRE;
                        end
                    end
                end
                CAL_FIRE: cal_st_d = CAL_IDLE;
                default:  cal_st_d = CAL_IDLE;
            endcase
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q       <= ST_IDLE;
            rd_cnt_q   <= '0;
            cal_st_q   <= CAL_IDLE;
            cal_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 2'd0;
            man_sel_q  <= 2'd0;
            man_coef_q <= '0;
            man_lock_q <= 1'b0;
            cal_stb_q  <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            st_q       <= st_d;
            rd_cnt_q   <= rd_cnt_d;
            cal_st_q   <= cal_st_d;
            cal_cnt_q  <= cal_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            man_sel_q  <= man_sel_d;
            man_coef_q <= man_coef_d;
            man_lock_q <= man_lock_d;
            cal_stb_q  <= cal_stb_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
        end
    end

    assign csr_rdata_o        = rdata_q;
    assign csr_ready_o        = ready_q;
    assign wb_ctrl_o.mode     = mode_q;
    assign wb_ctrl_o.man_sel  = man_sel_q;
    assign wb_ctrl_o.man_coef = man_coef_q;
    assign wb_ctrl_o.man_lock = man_lock_q;
    assign wb_ctrl_o.cal_stb  = cal_stb_q;
endmodule

// File: tb/tb_wb_ctrl_sequencer.sv
// Bench for wb_ctrl_sequencer: directed scenarios plus random CSR/sof traffic,
// with expected responses queued by a reference model and popped by monitors.
module tb_wb_ctrl_sequencer;
    localparam int PXW  = 10;
    localparam int FW   = 10;
    localparam int CW   = PXW + FW;
    localparam int CALF = 2;
    localparam int RDW  = 2;
    localparam logic [31:0] MASK = (32'd1 << CW) - 32'd1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  csr_addr_i = '0;
    logic        csr_wr_i = 1'b0;
    logic        csr_rd_i = 1'b0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_ready_o;
    logic        sof_i = 1'b0;

    wb_ctrl_if wb();

    wb_ctrl_sequencer #(.PX_WIDTH(PXW), .FRACT_WIDTH(FW), .CAL_FRAMES(CALF), .RD_WAIT(RDW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr_addr_i(csr_addr_i), .csr_wr_i(csr_wr_i),
        .csr_rd_i(csr_rd_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
        .csr_ready_o(csr_ready_o), .sof_i(sof_i), .wb_ctrl_o(wb)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Corrector stand-in: latches locked coefficients, registers cur_coef from man_sel
    logic [31:0] store [4];
    initial for (int i = 0; i < 4; i++) store[i] = '0;
    always @(posedge clk_i) begin
        if (wb.man_lock) store[wb.man_sel] <= wb.man_coef;
        wb.cur_coef <= store[wb.man_sel];
    end

    typedef struct { int due; logic chk; logic [31:0] data; } rsp_t;
    typedef struct { int due; logic [1:0] sel; logic [31:0] coef; } lock_t;
    rsp_t  rsp_q[$];
    lock_t lock_q[$];
    int    stb_q[$];
    rsp_t  mr;
    lock_t ml;
    int    ms;

    int checks = 0;
    int failures = 0;
    int n_resp = 0;

    // Reference model state
    logic [1:0]  m_mode = 2'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_frames = 0;
    logic [31:0] m_coef [3] = '{32'd0, 32'd0, 32'd0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Monitors: pop and compare whenever the DUT presents ready, man_lock or cal_stb
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (csr_ready_o) begin
                n_resp++;
                if (rsp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
                else begin
                    mr = rsp_q.pop_front();
                    chk("ready_cycle", cyc, mr.due);
                    if (mr.chk) chk("rdata", csr_rdata_o, mr.data);
                end
            end
            if (wb.man_lock) begin
                if (lock_q.size() == 0) chk("unexpected_man_lock", 32'd1, 32'd0);
                else begin
                    ml = lock_q.pop_front();
                    chk("lock_cycle", cyc, ml.due);
                    chk("lock_sel", {30'd0, wb.man_sel}, {30'd0, ml.sel});
                    chk("lock_coef", wb.man_coef, ml.coef);
                end
            end
            if (wb.cal_stb) begin
                if (stb_q.size() == 0) chk("unexpected_cal_stb", 32'd1, 32'd0);
                else begin
                    ms = stb_q.pop_front();
                    chk("cal_stb_cycle", cyc, ms);
                end
            end
        end
    end

    // Drive one request for one cycle and queue what the model expects
    task automatic req_start(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d);
        rsp_t r;
        int   lat;
        int   idx;
        @(posedge clk_i); #1;
        csr_wr_i = wr; csr_rd_i = rd; csr_addr_i = a; csr_wdata_i = d;
        lat = 1; r.chk = 1'b0; r.data = '0;
        idx = int'(a) - 1;
        if (wr) begin
            if (a == 3'd0) begin
                m_mode = d[1:0];
                m_busy = 1'b0;
            end else if (a >= 3'd1 && a <= 3'd3) begin
                lat = 2;
                m_coef[idx] = d;
                lock_q.push_back('{cyc + 1, 2'(idx), d});
            end else if (a == 3'd4 && d[0]) begin
                m_mode = 2'd3; m_busy = 1'b1; m_done = 1'b0; m_frames = 0;
            end
        end else if (rd) begin
            r.chk = 1'b1;
            if (a == 3'd0) r.data = {30'd0, m_mode};
            else if (a >= 3'd1 && a <= 3'd3) begin
                lat = RDW + 2;
                r.data = m_coef[idx] & MASK;
            end else if (a == 3'd4) begin
                r.data = {30'd0, m_done, m_busy};
                m_done = 1'b0;
            end
        end
        r.due = cyc + lat;
        rsp_q.push_back(r);
        @(posedge clk_i); #1;
        csr_wr_i = 1'b0; csr_rd_i = 1'b0;
    endtask

    task automatic req(input logic wr, input logic rd, input logic [2:0] a, input logic [31:0] d);
        int start;
        start = n_resp;
        req_start(wr, rd, a, d);
        for (int i = 0; i < 40 && n_resp == start; i++) @(posedge clk_i);
        #1;
        if (n_resp == start) begin
            chk("resp_timeout", 32'd0, 32'd1);
            rsp_q.delete();
        end
        chk("mode", {30'd0, wb.mode}, {30'd0, m_mode});
    endtask

    task automatic sof_pulse();
        @(posedge clk_i); #1;
        sof_i = 1'b1;
        if (m_busy) begin
            m_frames++;
            if (m_frames == CALF) begin
                stb_q.push_back(cyc + 1);
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        @(posedge clk_i); #1;
        sof_i = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_rdata", csr_rdata_o, 32'd0);
        chk("rst_ready", {31'd0, csr_ready_o}, 32'd0);
        chk("rst_mode", {30'd0, wb.mode}, 32'd0);
        chk("rst_man_sel", {30'd0, wb.man_sel}, 32'd0);
        chk("rst_man_coef", wb.man_coef, 32'd0);
        chk("rst_man_lock", {31'd0, wb.man_lock}, 32'd0);
        chk("rst_cal_stb", {31'd0, wb.cal_stb}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        rsp_q.delete(); lock_q.delete(); stb_q.delete();
        m_mode = 2'd0; m_busy = 1'b0; m_done = 1'b0; m_frames = 0;
        @(posedge clk_i); #1;
        check_reset_vals();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int start;
        logic [2:0] a;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_vals();
        rst_i = 1'b0;

        // Reset read-back
        req(1'b0, 1'b1, 3'd0, 32'd0);
        req(1'b0, 1'b1, 3'd4, 32'd0);

        // Mode, coefficient write and read-back (upper bits pass through, read masked)
        req(1'b1, 1'b0, 3'd0, 32'd2);
        req(1'b1, 1'b0, 3'd1, 32'h0000_0C00);
        req(1'b0, 1'b1, 3'd1, 32'd0);
        req(1'b1, 1'b0, 3'd3, 32'hABCD_1234);
        req(1'b0, 1'b1, 3'd3, 32'd0);

        // Write beats read; unmapped addresses
        req(1'b1, 1'b1, 3'd2, 32'h0000_0400);
        req(1'b0, 1'b1, 3'd6, 32'd0);
        req(1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF);
        req(1'b0, 1'b1, 3'd2, 32'd0);

        // Calibration run
        req(1'b1, 1'b0, 3'd4, 32'd1);
        req(1'b0, 1'b1, 3'd4, 32'd0);
        for (int i = 0; i < 3; i++) begin
            sof_pulse();
            repeat (100) @(posedge clk_i);
        end
        req(1'b0, 1'b1, 3'd4, 32'd0);
        req(1'b0, 1'b1, 3'd4, 32'd0);

        // Cancel by MODE write
        req(1'b1, 1'b0, 3'd4, 32'd1);
        sof_pulse();
        req(1'b1, 1'b0, 3'd0, 32'd1);
        sof_pulse();
        sof_pulse();
        req(1'b0, 1'b1, 3'd4, 32'd0);

        // Re-arm restarts the count
        req(1'b1, 1'b0, 3'd4, 32'd1);
        sof_pulse();
        req(1'b1, 1'b0, 3'd4, 32'd1);
        sof_pulse();
        req(1'b0, 1'b1, 3'd4, 32'd0);
        sof_pulse();
        req(1'b0, 1'b1, 3'd4, 32'd0);

        // Reset in RD_WAIT
        req_start(1'b0, 1'b1, 3'd1, 32'd0);
        do_reset();
        start = n_resp;
        repeat (10) @(posedge clk_i);
        #1;
        chk("no_ready_after_reset", n_resp, start);

        // Reset in CAL_COUNT
        req(1'b1, 1'b0, 3'd4, 32'd1);
        sof_pulse();
        do_reset();
        sof_pulse();
        sof_pulse();
        repeat (5) @(posedge clk_i);
        req(1'b0, 1'b1, 3'd4, 32'd0);
        req(1'b0, 1'b1, 3'd1, 32'd0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0: req(1'b1, 1'b0, 3'd0, $urandom);
                1, 2: req(1'b1, $urandom_range(0, 1) == 1, 3'($urandom_range(1, 3)), $urandom);
                3, 4: req(1'b0, 1'b1, 3'($urandom_range(1, 3)), 32'd0);
                5: req(1'b0, 1'b1, 3'd0, 32'd0);
                6: req(1'b0, 1'b1, 3'd4, 32'd0);
                7: req(1'b1, 1'b0, 3'd4, $urandom);
                8: sof_pulse();
                default: begin
                    a = 3'($urandom_range(5, 7));
                    if ($urandom_range(0, 1) == 1) req(1'b1, 1'b0, a, $urandom);
                    else req(1'b0, 1'b1, a, 32'd0);
                end
            endcase
        end

        repeat (10) @(posedge clk_i);
        #1;
        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        chk("lock_q_empty", lock_q.size(), 32'd0);
        chk("stb_q_empty", stb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
